// File: rtl/vending_pkg.sv
// Shared definitions for the change dispenser: coin values in nickel units,
// dispenser state encoding and the coin-select code.
package vending_pkg;

  localparam int NICKLE  = 1;
  localparam int DIME    = 2;
  localparam int QUARTER = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_EJECT,
    ST_GAP,
    ST_DONE
  } disp_state_e;

  typedef enum logic [1:0] {
    COIN_NONE,
    COIN_QUARTER,
    COIN_DIME,
    COIN_NICKLE
  } coin_sel_e;

endpackage

// File: rtl/change_dispenser_coin_tube.sv
// One coin-tube inventory: loads its full count on reset/refill and counts
// down once per ejected coin; never decrements past zero.
module coin_tube #(
  parameter int TUBE_W = 4,
  parameter int INIT   = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_dec,
  output logic [TUBE_W-1:0] o_count,
  output logic              o_empty
);

  assign o_empty = (o_count == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_count <= TUBE_W'(INIT);
    end else if (i_load) begin
      o_count <= TUBE_W'(INIT);
    end else if (i_dec && !o_empty) begin
      o_count <= o_count - TUBE_W'(1);
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change payout controller: greedy quarter/dime/nickel selection, one coin at
// a time through the ejector, with per-denomination tube inventories.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int CHANGE_W = 3,
  parameter int TUBE_W   = 4,
  parameter int INIT_Q   = 4,
  parameter int INIT_D   = 8,
  parameter int INIT_N   = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_vend,
  input  logic [CHANGE_W-1:0] i_change,
  input  logic                i_refill,
  input  logic                i_coin_ack,
  output logic                o_eject_quarter,
  output logic                o_eject_dime,
  output logic                o_eject_nickle,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_short,
  output logic [TUBE_W-1:0]   o_q_cnt,
  output logic [TUBE_W-1:0]   o_d_cnt,
  output logic [TUBE_W-1:0]   o_n_cnt,
  output disp_state_e         o_state
);

  localparam logic [CHANGE_W-1:0] Q_VAL = CHANGE_W'(QUARTER);
  localparam logic [CHANGE_W-1:0] D_VAL = CHANGE_W'(DIME);
  localparam logic [CHANGE_W-1:0] N_VAL = CHANGE_W'(NICKLE);

  disp_state_e         state;
  coin_sel_e           sel;
  coin_sel_e           pick;
  logic [CHANGE_W-1:0] rem;
  logic [CHANGE_W-1:0] sel_val;
  logic                q_empty, d_empty, n_empty;
  logic                tube_load, coin_taken;

  assign o_state    = state;
  assign tube_load  = (state == ST_IDLE) && !i_vend && i_refill;
  assign coin_taken = (state == ST_EJECT) && i_coin_ack;

  coin_tube #(.TUBE_W(TUBE_W), .INIT(INIT_Q)) u_tube_q (
    .i_clk(i_clk), .i_rst(i_rst), .i_load(tube_load),
    .i_dec(coin_taken && (sel == COIN_QUARTER)),
    .o_count(o_q_cnt), .o_empty(q_empty)
  );

  coin_tube #(.TUBE_W(TUBE_W), .INIT(INIT_D)) u_tube_d (
    .i_clk(i_clk), .i_rst(i_rst), .i_load(tube_load),
    .i_dec(coin_taken && (sel == COIN_DIME)),
    .o_count(o_d_cnt), .o_empty(d_empty)
  );

  coin_tube #(.TUBE_W(TUBE_W), .INIT(INIT_N)) u_tube_n (
    .i_clk(i_clk), .i_rst(i_rst), .i_load(tube_load),
    .i_dec(coin_taken && (sel == COIN_NICKLE)),
    .o_count(o_n_cnt), .o_empty(n_empty)
  );

  // Largest coin that fits in the remainder and is still in stock.
  always_comb begin
    pick = COIN_NONE;
    if (rem >= Q_VAL && !q_empty)      pick = COIN_QUARTER;
    else if (rem >= D_VAL && !d_empty) pick = COIN_DIME;
    else if (rem >= N_VAL && !n_empty) pick = COIN_NICKLE;
  end

  always_comb begin
    sel_val = '0;
    case (sel)
      COIN_QUARTER: sel_val = Q_VAL;
      COIN_DIME:    sel_val = D_VAL;
      COIN_NICKLE:  sel_val = N_VAL;
      default:      sel_val = '0;
    endcase
  end

  // Eject/ack handshake: an eject request stays high until i_coin_ack is
  // sampled high; the coin is counted and the request dropped on that edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= ST_IDLE;
      sel             <= COIN_NONE;
      rem             <= '0;
      o_eject_quarter <= 1'b0;
      o_eject_dime    <= 1'b0;
      o_eject_nickle  <= 1'b0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_short         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_vend) begin
            rem     <= i_change;
            o_short <= 1'b0;
            o_busy  <= 1'b1;
            state   <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (rem == '0) begin
            o_done <= 1'b1;
            state  <= ST_DONE;
          end else if (pick == COIN_NONE) begin
            o_short <= 1'b1;
            rem     <= '0;
            o_done  <= 1'b1;
            state   <= ST_DONE;
          end else begin
            sel             <= pick;
            o_eject_quarter <= (pick == COIN_QUARTER);
            o_eject_dime    <= (pick == COIN_DIME);
            o_eject_nickle  <= (pick == COIN_NICKLE);
            state           <= ST_EJECT;
          end
        end
        ST_EJECT: begin
          if (i_coin_ack) begin
            o_eject_quarter <= 1'b0;
            o_eject_dime    <= 1'b0;
            o_eject_nickle  <= 1'b0;
            rem             <= rem - sel_val;
            state           <= ST_GAP;
          end
        end
        ST_GAP: begin
          state <= ST_SELECT;
        end
        ST_DONE: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: transaction-level greedy payout model,
// per-cycle compare process and literal checks on timing and inventories.
module tb_change_dispenser;
  import vending_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_vend = 1'b0;
  logic [2:0] i_change = '0;
  logic       i_refill = 1'b0;
  logic       i_coin_ack = 1'b0;
  logic       o_eject_quarter, o_eject_dime, o_eject_nickle;
  logic       o_busy, o_done, o_short;
  logic [3:0] o_q_cnt, o_d_cnt, o_n_cnt;
  disp_state_e dbg_state;

  change_dispenser #(
    .CHANGE_W(3), .TUBE_W(4), .INIT_Q(4), .INIT_D(8), .INIT_N(8)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_vend(i_vend), .i_change(i_change),
    .i_refill(i_refill), .i_coin_ack(i_coin_ack),
    .o_eject_quarter(o_eject_quarter), .o_eject_dime(o_eject_dime),
    .o_eject_nickle(o_eject_nickle), .o_busy(o_busy), .o_done(o_done),
    .o_short(o_short), .o_q_cnt(o_q_cnt), .o_d_cnt(o_d_cnt), .o_n_cnt(o_n_cnt),
    .o_state(dbg_state)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: tube stock, expected coin sequence {q,d,n} one-hot, short flag
  int mq = 4, md = 8, mn = 8;
  bit exp_short = 0;
  logic [2:0] exp_q[$];

  task automatic model_vend(input int chg);
    int r;
    r = chg;
    exp_short = 0;
    while (r > 0) begin
      if (r >= 5 && mq > 0)      begin exp_q.push_back(3'b100); mq--; r -= 5; end
      else if (r >= 2 && md > 0) begin exp_q.push_back(3'b010); md--; r -= 2; end
      else if (r >= 1 && mn > 0) begin exp_q.push_back(3'b001); mn--; r -= 1; end
      else begin exp_short = 1; r = 0; end
    end
  endtask

  task automatic model_reset();
    mq = 4; md = 8; mn = 8;
    exp_short = 0;
    exp_q.delete();
  endtask

  // scoreboard / compare process
  logic [2:0] prev_ej = '0;
  always @(negedge i_clk) begin
    logic [2:0] ej;
    ej = {o_eject_quarter, o_eject_dime, o_eject_nickle};
    if (i_rst) begin
      prev_ej = '0;
    end else begin
      if (ej != 3'b000) begin
        chk("eject_onehot", ($countones(ej) <= 1) ? 1 : 0, 1);
        chk("eject_busy", o_busy, 1);
        if (prev_ej == 3'b000) begin
          if (exp_q.size() == 0) chk("eject_unexpected", ej, 0);
          else chk("eject_coin", ej, exp_q.pop_front());
        end
      end
      if (o_done) begin
        chk("done_short", o_short, exp_short);
        chk("done_coins_left", exp_q.size(), 0);
        chk("done_q_cnt", o_q_cnt, mq);
        chk("done_d_cnt", o_d_cnt, md);
        chk("done_n_cnt", o_n_cnt, mn);
      end
      prev_ej = ej;
    end
  end

  // driver tasks (entered and left #1 after a rising edge)
  int first_evt;
  bit done_short;

  task automatic refill();
    i_refill = 1'b1;
    @(posedge i_clk); #1;
    i_refill = 1'b0;
    mq = 4; md = 8; mn = 8;
  endtask

  task automatic payout(input int chg, input int ack_dly, input int hold, input bit with_refill);
    int cyc;
    bit fin;
    bit held;
    model_vend(chg);
    i_vend   = 1'b1;
    i_change = 3'(chg);
    i_refill = with_refill;
    cyc = 0; fin = 0; held = 0; first_evt = -1;
    while (!fin && cyc < 300) begin
      @(posedge i_clk); #1; cyc++;
      i_vend = 1'b0;
      i_refill = 1'b0;
      if (o_done) begin
        fin = 1;
        done_short = o_short;
        if (first_evt < 0) first_evt = cyc;
      end else if (o_eject_quarter || o_eject_dime || o_eject_nickle) begin
        if (first_evt < 0) first_evt = cyc;
        if (hold > 0 && !held) begin
          logic [2:0] ej0;
          held = 1;
          ej0 = {o_eject_quarter, o_eject_dime, o_eject_nickle};
          i_vend = 1'b1; i_change = 3'd7; i_refill = 1'b1;
          for (int i = 0; i < hold; i++) begin
            @(posedge i_clk); #1; cyc++;
            i_vend = 1'b0; i_refill = 1'b0;
            chk("hold_eject", {o_eject_quarter, o_eject_dime, o_eject_nickle}, ej0);
            chk("hold_busy", o_busy, 1);
          end
        end
        repeat (ack_dly) begin @(posedge i_clk); #1; cyc++; end
        i_coin_ack = 1'b1;
        @(posedge i_clk); #1; cyc++;
        i_coin_ack = 1'b0;
      end
    end
    if (!fin) chk("payout_timeout", 0, 1);
    @(posedge i_clk); #1;
  endtask

  initial begin
    // reset
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_eject", {o_eject_quarter, o_eject_dime, o_eject_nickle}, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_short", o_short, 0);
    chk("rst_q", o_q_cnt, 4);
    chk("rst_d", o_d_cnt, 8);
    chk("rst_n", o_n_cnt, 8);

    // 1: 35c with full tubes -> quarter, dime
    payout(7, 1, 0, 0);
    chk("t1_first_eject_latency", first_evt, 2);
    chk("t1_q", o_q_cnt, 3);
    chk("t1_d", o_d_cnt, 7);
    chk("t1_n", o_n_cnt, 8);
    chk("t1_short", o_short, 0);

    // 2: drain dimes, then 20c paid in nickels
    repeat (7) payout(2, 0, 0, 0);
    chk("t2_d_empty", o_d_cnt, 0);
    payout(4, 1, 0, 0);
    chk("t2_n", o_n_cnt, 4);
    chk("t2_q", o_q_cnt, 3);
    chk("t2_short", o_short, 0);

    // 3: d=1, n=0, 15c -> one dime then short
    refill();
    chk("t3_refill_q", o_q_cnt, 4);
    chk("t3_refill_d", o_d_cnt, 8);
    chk("t3_refill_n", o_n_cnt, 8);
    repeat (8) payout(1, 0, 0, 0);
    repeat (7) payout(2, 0, 0, 0);
    chk("t3_pre_d", o_d_cnt, 1);
    chk("t3_pre_n", o_n_cnt, 0);
    payout(3, 1, 0, 0);
    chk("t3_short_at_done", done_short, 1);
    chk("t3_short_sticky", o_short, 1);
    chk("t3_d", o_d_cnt, 0);

    // 4: zero change -> done two edges after the vend edge, no eject
    model_vend(0);
    i_vend = 1'b1; i_change = 3'd0;
    @(posedge i_clk); #1; i_vend = 1'b0;
    chk("t4_c1_busy", o_busy, 1);
    chk("t4_c1_done", o_done, 0);
    chk("t4_c1_short_cleared", o_short, 0);
    @(posedge i_clk); #1;
    chk("t4_c2_busy", o_busy, 1);
    chk("t4_c2_done", o_done, 1);
    chk("t4_c2_eject", {o_eject_quarter, o_eject_dime, o_eject_nickle}, 0);
    @(posedge i_clk); #1;
    chk("t4_c3_busy", o_busy, 0);
    chk("t4_c3_done", o_done, 0);

    // vend and refill together in IDLE: refill dropped
    payout(0, 0, 0, 1);
    chk("t4b_d_not_refilled", o_d_cnt, 0);
    chk("t4b_n_not_refilled", o_n_cnt, 0);

    // 5: vend+refill during EJECT ignored, ack withheld 20 cycles
    refill();
    payout(2, 0, 0, 0);
    payout(5, 0, 20, 0);
    chk("t5_q", o_q_cnt, 3);
    chk("t5_d", o_d_cnt, 7);
    chk("t5_n", o_n_cnt, 8);
    chk("t5_short", o_short, 0);
    chk("t5_idle", o_busy, 0);

    // 6: reset mid-EJECT
    model_vend(5);
    i_vend = 1'b1; i_change = 3'd5;
    @(posedge i_clk); #1; i_vend = 1'b0;
    @(posedge i_clk); #1;
    chk("t6_eject_up", o_eject_quarter, 1);
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    #1;
    chk("t6_eject_low", {o_eject_quarter, o_eject_dime, o_eject_nickle}, 0);
    chk("t6_busy_low", o_busy, 0);
    chk("t6_q", o_q_cnt, 4);
    chk("t6_d", o_d_cnt, 8);
    chk("t6_n", o_n_cnt, 8);
    model_reset();
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge i_clk); #1;
      chk("t6_no_done", o_done, 0);
      chk("t6_stay_idle", o_busy, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
